fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of exec_unit in the rv32i core.
- Drives the read port of memsys to fetch 32-bit instructions at a sequential PC.
- Buffers fetched words in a small prefetch FIFO and hands them to exec_unit over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from exec_unit and flushes stale instructions.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i front end (fetch FSM states, prefetch entries).
package rv32i_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // pc is held at full 32-bit width; the fetch unit uses the low ADDR_BITS.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t. Flush empties it and overrides push/pop in the same cycle.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_V);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || pop) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with prefetch FIFO and redirect flush.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int                   ADDR_BITS  = 16,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 rd_mem_en,
  output logic [ADDR_BITS-1:0] rd_mem_addr,
  input  logic [31:0]          rd_mem_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr_data,
  output logic [ADDR_BITS-1:0] instr_pc,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_flushed
`endif
);

  // Handshake: a transfer happens in any cycle with instr_valid && instr_ready;
  // the head entry is held stable while valid is high and ready is low.

  localparam int                   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]          DEPTH_V = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(INSTR_BYTES);
  localparam logic [ADDR_BITS-1:0] PC_INIT = {RESET_PC[ADDR_BITS-1:2], 2'b00};

  fetch_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d, issue_pc_q;
  logic                 inflight_q;
  logic                 issue, push, pop;
  logic [CW:0]          occupancy;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  fetch_entry_t         push_entry, head;
  logic [31:0]          head_pc_unused;

  assign pop         = !fifo_empty && instr_ready;
  assign push        = inflight_q && !redirect_valid;
  assign instr_valid = !fifo_empty;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc[ADDR_BITS-1:0];
  assign head_pc_unused = head.pc;

  assign push_entry.instr = rd_mem_data;
  assign push_entry.pc    = 32'(issue_pc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:     state_d = redirect_valid ? REDIRECT : RUN;
      RUN:      if (redirect_valid) state_d = REDIRECT;
      REDIRECT: state_d = redirect_valid ? REDIRECT : RUN;
      default:  state_d = BOOT;
    endcase
  end

  // A pop this cycle frees a slot, so issue may proceed even at full occupancy.
  always_comb begin
    occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    issue       = (state_q == RUN) && !redirect_valid && ((occupancy < DEPTH_V) || pop);
    rd_mem_en   = issue;
    rd_mem_addr = issue ? pc_q : '0;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[ADDR_BITS-1:2], 2'b00};
    else if (issue)     pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_INIT;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) issue_pc_q <= pc_q;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_flushed_q;

  // Discarded = entries left after this cycle's pop, plus the response being dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (pop) stat_fetched_q <= stat_fetched_q + 32'd1;
      if (redirect_valid)
        stat_flushed_q <= stat_flushed_q + 32'(fifo_count) - 32'(pop) + 32'(inflight_q);
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirects, PC wrap, async reset.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_mem_en;
  logic [15:0] rd_mem_addr;
  logic [31:0] rd_mem_data = 32'hDEAD_BEEF;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [15:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  fetch_unit #(.ADDR_BITS(16), .RESET_PC(16'h0100), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_mem_en      (rd_mem_en),
    .rd_mem_addr    (rd_mem_addr),
    .rd_mem_data    (rd_mem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  // clock / memsys responder: word[i] = i, data one cycle after the request
  always #5 clk = ~clk;

  always @(posedge clk)
    rd_mem_data <= rd_mem_en ? {16'h0000, 2'b00, rd_mem_addr[15:2]} : 32'hDEAD_BEEF;

  // Leaves the bench at the negedge where reset drops (call it cycle 0).
  task automatic do_reset(input logic ready);
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = ready;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rd_mem_en, rd_mem_addr} !== 17'h0) begin
      errors++;
      $display("FAIL reset_rd got en=%0b addr=%h exp en=0 addr=0000", rd_mem_en, rd_mem_addr);
    end
    checks++;
    if ({instr_valid, instr_data, instr_pc} !== 49'h0) begin
      errors++;
      $display("FAIL reset_instr got v=%0b data=%h pc=%h exp all 0", instr_valid, instr_data, instr_pc);
    end
    do_reset(1'b1);
    #1;
    checks++;
    if ({rd_mem_en, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL boot_idle got en=%0b v=%0b exp 0 0", rd_mem_en, instr_valid);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_a, exp_pc;
    do_reset(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      exp_a = 16'h0100 + 16'(4 * (k - 1));
      checks++;
      if ({rd_mem_en, rd_mem_addr} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL stream_fetch k=%0d got en=%0b addr=%h exp en=1 addr=%h", k, rd_mem_en, rd_mem_addr, exp_a);
      end
      exp_pc = 16'h0100 + 16'(4 * (k - 3));
      checks++;
      if (k < 3) begin
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early k=%0d got v=%0b exp v=0", k, instr_valid);
        end
      end else if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, 18'h0, exp_pc[15:2]}) begin
        errors++;
        $display("FAIL stream_out k=%0d got v=%0b pc=%h data=%h exp pc=%h", k, instr_valid, instr_pc, instr_data, exp_pc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc, exp_a;
    do_reset(1'b0);
    exp_q = {16'h0100, 16'h0104, 16'h0108};
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      exp_a = (k == 1) ? 16'h0100 : 16'h0104;
      checks++;
      if ((k <= 2) ? ({rd_mem_en, rd_mem_addr} !== {1'b1, exp_a}) : (rd_mem_en !== 1'b0)) begin
        errors++;
        $display("FAIL bp_issue k=%0d got en=%0b addr=%h exp en=%0b", k, rd_mem_en, rd_mem_addr, k <= 2);
      end
      if (k >= 3) begin
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 16'h0100, 32'h0000_0040}) begin
          errors++;
          $display("FAIL bp_hold k=%0d got v=%0b pc=%h data=%h exp pc=0100 data=00000040", k, instr_valid, instr_pc, instr_data);
        end
      end
    end
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      exp_pc = exp_q.pop_front();
      exp_a = 16'h0108 + 16'(4 * (k - 6));
      checks++;
      if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, 18'h0, exp_pc[15:2]}) begin
        errors++;
        $display("FAIL bp_drain k=%0d got v=%0b pc=%h data=%h exp pc=%h", k, instr_valid, instr_pc, instr_data, exp_pc);
      end
      checks++;
      if ({rd_mem_en, rd_mem_addr} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL bp_refill k=%0d got en=%0b addr=%h exp addr=%h", k, rd_mem_en, rd_mem_addr, exp_a);
      end
    end
  endtask

  task automatic test_redirect();
    // full FIFO (2 entries), nothing in flight, redirect to unaligned 0x0203
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0203;
    #1;
    checks++;
    if (rd_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL redir_no_issue got en=%0b exp 0", rd_mem_en);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #1;
    checks++;
    if ({instr_valid, rd_mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL redir_flush got v=%0b en=%0b exp 0 0", instr_valid, rd_mem_en);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stat_flushed !== 32'd2) begin
      errors++;
      $display("FAIL redir_stat_flushed got %0d exp 2", stat_flushed);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if ({rd_mem_en, rd_mem_addr, instr_valid} !== {1'b1, 16'h0200, 1'b0}) begin
      errors++;
      $display("FAIL redir_first_fetch got en=%0b addr=%h v=%0b exp addr=0200", rd_mem_en, rd_mem_addr, instr_valid);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 16'h0200, 32'h0000_0080}) begin
      errors++;
      $display("FAIL redir_first_out got v=%0b pc=%h data=%h exp pc=0200 data=00000080", instr_valid, instr_pc, instr_data);
    end

    // redirect while the 0x0100 response is in flight: it must be dropped
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({instr_valid, rd_mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL redir_inflight_drop got v=%0b pc=%h en=%0b exp v=0 en=0", instr_valid, instr_pc, rd_mem_en);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stat_flushed !== 32'd1) begin
      errors++;
      $display("FAIL redir_inflight_stat got %0d exp 1", stat_flushed);
    end
`endif
    @(negedge clk);
    #1;
    checks++;
    if ({rd_mem_en, rd_mem_addr} !== {1'b1, 16'h0300}) begin
      errors++;
      $display("FAIL redir_inflight_fetch got en=%0b addr=%h exp addr=0300", rd_mem_en, rd_mem_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 16'h0300, 32'h0000_00C0}) begin
      errors++;
      $display("FAIL redir_inflight_out got v=%0b pc=%h data=%h exp pc=0300", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc;
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0400;
    #1;
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0100}) begin
      errors++;
      $display("FAIL b2b_handshake got v=%0b pc=%h exp v=1 pc=0100", instr_valid, instr_pc);
    end
    @(negedge clk);
    redirect_pc = 16'h0800;
    for (int k = 4; k <= 10; k++) begin
      if (k == 5) begin
        @(negedge clk);
        redirect_valid = 1'b0;
      end else if (k > 5) begin
        @(negedge clk);
      end
      #1;
      if (k <= 7) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap k=%0d got v=%0b pc=%h exp v=0", k, instr_valid, instr_pc);
        end
      end else begin
        exp_pc = 16'h0800 + 16'(4 * (k - 8));
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, 18'h0, exp_pc[15:2]}) begin
          errors++;
          $display("FAIL b2b_out k=%0d got v=%0b pc=%h data=%h exp pc=%h", k, instr_valid, instr_pc, instr_data, exp_pc);
        end
      end
      if (k == 6) begin
        checks++;
        if ({rd_mem_en, rd_mem_addr} !== {1'b1, 16'h0800}) begin
          errors++;
          $display("FAIL b2b_fetch got en=%0b addr=%h exp addr=0800", rd_mem_en, rd_mem_addr);
        end
      end
    end
`ifdef FETCH_STATS_EN
    checks++;
    if ({stat_fetched, stat_flushed} !== {32'd3, 32'd1}) begin
      errors++;
      $display("FAIL b2b_stats got fetched=%0d flushed=%0d exp 3 1", stat_fetched, stat_flushed);
    end
`endif
  endtask

  task automatic test_pc_wrap();
    logic [15:0] exp_a, exp_pc;
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (rd_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL wrap_bubble got en=%0b exp 0", rd_mem_en);
    end
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      #1;
      if (k <= 5) begin
        exp_a = 16'hFFF8 + 16'(4 * (k - 2));
        checks++;
        if ({rd_mem_en, rd_mem_addr} !== {1'b1, exp_a}) begin
          errors++;
          $display("FAIL wrap_fetch k=%0d got en=%0b addr=%h exp addr=%h", k, rd_mem_en, rd_mem_addr, exp_a);
        end
      end
      if (k >= 4) begin
        exp_pc = 16'hFFF8 + 16'(4 * (k - 4));
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, exp_pc, 18'h0, exp_pc[15:2]}) begin
          errors++;
          $display("FAIL wrap_out k=%0d got v=%0b pc=%h data=%h exp pc=%h", k, instr_valid, instr_pc, instr_data, exp_pc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0100}) begin
      errors++;
      $display("FAIL areset_pre got v=%0b pc=%h exp v=1 pc=0100", instr_valid, instr_pc);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rd_mem_en, rd_mem_addr, instr_valid, instr_data, instr_pc} !== 66'h0) begin
      errors++;
      $display("FAIL areset_now got en=%0b addr=%h v=%0b data=%h pc=%h exp all 0", rd_mem_en, rd_mem_addr, instr_valid, instr_data, instr_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k <= 2) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL areset_stale k=%0d got v=%0b pc=%h data=%h exp v=0", k, instr_valid, instr_pc, instr_data);
        end
      end
      if (k == 1) begin
        checks++;
        if ({rd_mem_en, rd_mem_addr} !== {1'b1, 16'h0100}) begin
          errors++;
          $display("FAIL areset_refetch got en=%0b addr=%h exp addr=0100", rd_mem_en, rd_mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 16'h0100, 32'h0000_0040}) begin
          errors++;
          $display("FAIL areset_first_out got v=%0b pc=%h data=%h exp pc=0100 data=00000040", instr_valid, instr_pc, instr_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
